// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: state encodings and default widths,
// kept here so a future multi-voice arbiter can reuse them.
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } seq_state_e;

    localparam int DEF_FREQ_WIDTH = 8;
    localparam int DEF_DUR_WIDTH  = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_TICK_DIV   = 1000;

    // Counter width for a modulo-n count, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/note_sequencer_tick_prescaler.sv
// Modulo-TICK_DIV down-counter; tick is high for the one cycle the count hits zero
// while enabled. A clear restarts the full period.
module tick_prescaler
    import note_sequencer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CW   = cnt_width(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LAST;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? LAST : cnt_q - CW'(1);
        end
    end

    assign tick = en && !clr && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// One-voice note sequencer: steps through a {period code, duration} pattern memory
// and drives frequency_control and gate for the downstream waveform generator.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int FREQ_WIDTH = DEF_FREQ_WIDTH,
    parameter int DUR_WIDTH  = DEF_DUR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [FREQ_WIDTH-1:0] wr_freq,
    input  logic [DUR_WIDTH-1:0]  wr_dur,
    input  logic [ADDR_W:0]       seq_len,
    input  logic                  loop,
    input  logic                  start,
    input  logic                  stop,
    output logic [FREQ_WIDTH-1:0] frequency_control,
    output logic                  gate,
    output logic [ADDR_W-1:0]     step,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [FREQ_WIDTH-1:0] mem_freq [DEPTH];
    logic [DUR_WIDTH-1:0]  mem_dur  [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_freq[wr_addr] <= wr_freq;
            mem_dur[wr_addr]  <= wr_dur;
        end
    end

    seq_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     step_q, step_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic [FREQ_WIDTH-1:0] freq_q, freq_d;
    logic                  gate_q, gate_d;
    logic                  done_q, done_d;
    logic [DUR_WIDTH-1:0]  dur_cnt_q, dur_cnt_d;
    logic                  pre_clr, pre_en, tick;
    logic [ADDR_W:0]       step_next_ext;
    logic                  is_last;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    assign step_next_ext = {1'b0, step_q} + (ADDR_W + 1)'(1);
    assign is_last       = (step_next_ext >= len_q);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        len_d     = len_q;
        freq_d    = freq_q;
        gate_d    = gate_q;
        done_d    = 1'b0;
        dur_cnt_d = dur_cnt_q;
        pre_clr   = 1'b0;
        pre_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (seq_len != '0) begin
                        len_d   = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
                        step_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                pre_clr = 1'b1;
                if (stop) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    freq_d  = '0;
                    gate_d  = 1'b0;
                end else begin
                    freq_d    = mem_freq[step_q];
                    gate_d    = (mem_freq[step_q] != '0);
                    // Duration counts down to zero; a zero duration plays as one tick.
                    dur_cnt_d = (mem_dur[step_q] == '0) ? '0 : mem_dur[step_q] - DUR_WIDTH'(1);
                    state_d   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                pre_en = 1'b1;
                if (stop) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    freq_d  = '0;
                    gate_d  = 1'b0;
                end else if (tick && dur_cnt_q == '0) begin
                    gate_d = 1'b0;
                    if (!is_last) begin
                        step_d  = step_q + ADDR_W'(1);
                        state_d = ST_LOAD;
                    end else if (loop) begin
                        step_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        step_d  = '0;
                        freq_d  = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tick) begin
                    dur_cnt_d = dur_cnt_q - DUR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
                freq_d  = '0;
                gate_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            len_q     <= '0;
            freq_q    <= '0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            dur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            len_q     <= len_d;
            freq_q    <= freq_d;
            gate_q    <= gate_d;
            done_q    <= done_d;
            dur_cnt_q <= dur_cnt_d;
        end
    end

    assign frequency_control = freq_q;
    assign gate              = gate_q;
    assign step              = step_q;
    assign busy              = (state_q != ST_IDLE);
    assign done              = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with TICK_DIV=4: expected per-cycle traces
// are built from a shadow copy of the pattern memory and the step-timing rules.
module tb_note_sequencer;

    localparam int FW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TD    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [FW-1:0] wr_freq;
    logic [DW-1:0] wr_dur;
    logic [AW:0]   seq_len;
    logic          loop;
    logic          start;
    logic          stop;
    logic [FW-1:0] frequency_control;
    logic          gate;
    logic [AW-1:0] step;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    note_sequencer #(
        .FREQ_WIDTH (FW),
        .DUR_WIDTH  (DW),
        .DEPTH      (DEPTH),
        .TICK_DIV   (TD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_freq           (wr_freq),
        .wr_dur            (wr_dur),
        .seq_len           (seq_len),
        .loop              (loop),
        .start             (start),
        .stop              (stop),
        .frequency_control (frequency_control),
        .gate              (gate),
        .step              (step),
        .busy              (busy),
        .done              (done)
    );

    int checks   = 0;
    int failures = 0;

    logic [FW-1:0] sm_f [DEPTH];
    logic [DW-1:0] sm_d [DEPTH];

    typedef struct {
        logic          busy;
        logic          gate;
        logic          done;
        logic          chk_f;
        logic [AW-1:0] st;
        logic [FW-1:0] f;
    } exp_t;

    exp_t exp_q[$];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cyc(input logic b, input logic g, input logic d, input logic cf,
                            input logic [AW-1:0] s, input logic [FW-1:0] f);
        exp_t e;
        e.busy = b; e.gate = g; e.done = d; e.chk_f = cf; e.st = s; e.f = f;
        exp_q.push_back(e);
    endtask

    // One step: a LOAD cycle with the gate low, then max(dur,1)*TD sounding cycles.
    task automatic push_step(input int s, input logic [FW-1:0] f, input logic [DW-1:0] d);
        int n;
        n = ((d == 0) ? 1 : int'(d)) * TD;
        push_cyc(1'b1, 1'b0, 1'b0, 1'b0, AW'(s), '0);
        for (int i = 0; i < n; i++) push_cyc(1'b1, (f != 0), 1'b0, 1'b1, AW'(s), f);
    endtask

    task automatic push_end();
        push_cyc(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        push_cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic write_entry(input int a, input logic [FW-1:0] f, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_freq = f; wr_dur = d;
        cycle();
        wr_en = 1'b0;
        sm_f[a] = f; sm_d[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        checks++;
        if ({busy, gate, done, step, frequency_control} !== '0) begin
            failures++;
            $display("FAIL reset got busy=%b gate=%b done=%b step=%0d freq=%0d exp all 0",
                     busy, gate, done, step, frequency_control);
        end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        write_entry(0, 8'd10, 8'd2);
        write_entry(1, 8'd20, 8'd1);
        exp_q.delete();
        push_step(0, 8'd10, 8'd2);
        push_step(1, 8'd20, 8'd1);
        push_end();
        seq_len = 5'd2; loop = 1'b0; start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            exp_t e;
            cycle();
            start = 1'b0;
            e = exp_q[i];
            checks++;
            if (busy !== e.busy || gate !== e.gate || done !== e.done || step !== e.st ||
                (e.chk_f && frequency_control !== e.f)) begin
                failures++;
                $display("FAIL basic cyc=%0d got busy=%b gate=%b done=%b step=%0d freq=%0d exp busy=%b gate=%b done=%b step=%0d freq=%0d",
                         i, busy, gate, done, step, frequency_control, e.busy, e.gate, e.done, e.st, e.f);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int len;
            int n;
            for (int a = 0; a < DEPTH; a++)
                write_entry(a, ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                            8'($urandom_range(0, 2)));
            if (it == 0) begin
                write_entry(0, 8'd0, 8'd3);
                write_entry(1, 8'd7, 8'd0);
                len = 2;
            end else if (it == 5) begin
                len = 31;
            end else if (it == 4) begin
                len = $urandom_range(17, 30);
            end else begin
                len = $urandom_range(1, 6);
            end
            n = (len > DEPTH) ? DEPTH : len;
            exp_q.delete();
            for (int s = 0; s < n; s++) push_step(s, sm_f[s], sm_d[s]);
            push_end();
            seq_len = 5'(len); loop = 1'b0; start = 1'b1;
            for (int i = 0; i < exp_q.size(); i++) begin
                exp_t e;
                cycle();
                start = 1'b0;
                e = exp_q[i];
                checks++;
                if (busy !== e.busy || gate !== e.gate || done !== e.done || step !== e.st ||
                    (e.chk_f && frequency_control !== e.f)) begin
                    failures++;
                    $display("FAIL random it=%0d len=%0d cyc=%0d got busy=%b gate=%b done=%b step=%0d freq=%0d exp busy=%b gate=%b done=%b step=%0d freq=%0d",
                             it, len, i, busy, gate, done, step, frequency_control, e.busy, e.gate, e.done, e.st, e.f);
                end
            end
        end
    endtask

    // Looping playback with a rewrite of the sounding entry and a late loop release.
    task automatic test_loop_rewrite();
        int off_idx;
        write_entry(0, 8'd10, 8'd2);
        write_entry(1, 8'd20, 8'd1);
        exp_q.delete();
        push_step(0, 8'd10, 8'd2);
        push_step(1, 8'd20, 8'd1);
        push_step(0, 8'd30, 8'd1);
        off_idx = exp_q.size();
        push_step(1, 8'd20, 8'd1);
        push_end();
        seq_len = 5'd2; loop = 1'b1; start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            exp_t e;
            cycle();
            start = 1'b0;
            if (i == 2) begin
                wr_en = 1'b1; wr_addr = '0; wr_freq = 8'd30; wr_dur = 8'd1;
                sm_f[0] = 8'd30; sm_d[0] = 8'd1;
            end
            if (i == 3) wr_en = 1'b0;
            if (i == off_idx) loop = 1'b0;
            e = exp_q[i];
            checks++;
            if (busy !== e.busy || gate !== e.gate || done !== e.done || step !== e.st ||
                (e.chk_f && frequency_control !== e.f)) begin
                failures++;
                $display("FAIL loop cyc=%0d got busy=%b gate=%b done=%b step=%0d freq=%0d exp busy=%b gate=%b done=%b step=%0d freq=%0d",
                         i, busy, gate, done, step, frequency_control, e.busy, e.gate, e.done, e.st, e.f);
            end
        end
    endtask

    task automatic test_stop();
        write_entry(0, 8'd50, 8'd3);
        seq_len = 5'd1; loop = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat ($urandom_range(2, 9)) cycle();
        checks++;
        if (busy !== 1'b1 || gate !== 1'b1 || frequency_control !== 8'd50) begin
            failures++;
            $display("FAIL stop_pre got busy=%b gate=%b freq=%0d exp busy=1 gate=1 freq=50",
                     busy, gate, frequency_control);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        checks++;
        if ({busy, gate, done, step, frequency_control} !== '0) begin
            failures++;
            $display("FAIL stop got busy=%b gate=%b done=%b step=%0d freq=%0d exp all 0",
                     busy, gate, done, step, frequency_control);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL stop_after cyc=%0d got busy=%b done=%b exp busy=0 done=0", i, busy, done);
            end
        end
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || gate !== 1'b0) begin
            failures++;
            $display("FAIL start_stop got busy=%b done=%b gate=%b exp 0 0 0", busy, done, gate);
        end
        cycle();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_after got busy=%b exp busy=0", busy);
        end
    endtask

    task automatic test_zero_len();
        seq_len = 5'd0; loop = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || gate !== 1'b0 || frequency_control !== 8'd0) begin
            failures++;
            $display("FAIL zero_len got done=%b busy=%b gate=%b freq=%0d exp done=1 busy=0 gate=0 freq=0",
                     done, busy, gate, frequency_control);
        end
        cycle();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_after got done=%b busy=%b exp done=0 busy=0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        write_entry(0, 8'd50, 8'd3);
        write_entry(1, 8'd60, 8'd3);
        seq_len = 5'd2; loop = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        checks++;
        if (busy !== 1'b1 || gate !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got busy=%b gate=%b exp busy=1 gate=1", busy, gate);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if ({busy, gate, done, step, frequency_control} !== '0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b gate=%b done=%b step=%0d freq=%0d exp all 0",
                     busy, gate, done, step, frequency_control);
        end
        loop = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after got busy=%b done=%b exp busy=0 done=0", busy, done);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0;
        seq_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            sm_f[a] = '0; sm_d[a] = '0;
        end
        test_reset();
        test_basic();
        test_random();
        test_loop_rewrite();
        test_stop();
        test_zero_len();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
